// File: rtl/data_memory_unit_if.sv
// data_memory_unit_if: M-stage memory bus between the pipeline (master) and the data memory (slave).
// Signals: MemWriteM/MemtoRegM store/load strobes, ALUResultM byte address, WriteDataM store data,
// ReadDataM registered load data, StallM pipeline freeze, ErrorM access fault (DMEM_BOUNDS_CHECK_EN only).
interface data_memory_unit_if;
  logic        MemWriteM;
  logic        MemtoRegM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic        ErrorM;
  modport master (output MemWriteM, MemtoRegM, ALUResultM, WriteDataM, input ReadDataM, StallM, ErrorM);
  modport slave (input MemWriteM, MemtoRegM, ALUResultM, WriteDataM, output ReadDataM, StallM, ErrorM);
`else
  modport master (output MemWriteM, MemtoRegM, ALUResultM, WriteDataM, input ReadDataM, StallM);
  modport slave (input MemWriteM, MemtoRegM, ALUResultM, WriteDataM, output ReadDataM, StallM);
`endif
endinterface

// File: rtl/data_memory_unit.sv
// data_memory_unit: word-addressed data RAM serving M-stage loads/stores with a fixed multi-cycle latency.
// Ports: clk, rst_n (async active-low), bus (data_memory_unit_if.slave).
// Optional DMEM_BOUNDS_CHECK_EN: adds ErrorM and suppresses misaligned/out-of-range accesses.
module data_memory_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic clk,
  input logic rst_n,
  data_memory_unit_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [AW-1:0] addr_q, c_addr;
  logic [31:0] data_q, c_data;
  logic wr_q, rd_q, flt_q, c_wr, c_rd, c_flt, flt_in, req, idle, commit;
  logic [31:0] mem [DEPTH];
  assign req  = bus.MemWriteM | bus.MemtoRegM;
  assign idle = state == IDLE;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign flt_in = (bus.ALUResultM[1:0] != 2'b00) || (bus.ALUResultM[31:2] >= 30'(DEPTH));
`else
  assign flt_in = 1'b0;
`endif
  // In IDLE with LATENCY==1 the commit edge is the accepting edge, so the live inputs are used.
  assign c_addr = idle ? bus.ALUResultM[AW+1:2] : addr_q;
  assign c_data = idle ? bus.WriteDataM : data_q;
  assign c_wr   = idle ? bus.MemWriteM : wr_q;
  assign c_rd   = idle ? bus.MemtoRegM : rd_q;
  assign c_flt  = idle ? flt_in : flt_q;
  assign commit = nxt == DONE;
  // Gated by rst_n so the freeze drops the instant reset is asserted.
  assign bus.StallM = rst_n & ((idle & req) | (state == BUSY));
  always_comb begin
    nxt = idle ? (req ? (LATENCY == 1 ? DONE : BUSY) : IDLE) :
          state == BUSY ? (cnt == CW'(1) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      flt_q         <= 1'b0;
      bus.ReadDataM <= '0;
    end else begin
      state <= nxt;
      if (idle && req) begin
        cnt    <= CW'(LATENCY - 1);
        addr_q <= bus.ALUResultM[AW+1:2];
        data_q <= bus.WriteDataM;
        wr_q   <= bus.MemWriteM;
        rd_q   <= bus.MemtoRegM;
        flt_q  <= flt_in;
      end else if (state == BUSY) cnt <= cnt - CW'(1);
      if (commit && c_rd) bus.ReadDataM <= c_flt ? '0 : mem[c_addr];
    end
  end
`ifdef DMEM_BOUNDS_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else err_q <= commit & c_flt;
  end
  assign bus.ErrorM = err_q;
`endif
  // RAM is not reset; a store still pending when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (rst_n && commit && c_wr && !c_flt) mem[c_addr] <= c_data;
  end
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: randomized scoreboard bench driving two instances (LATENCY=2 and LATENCY=1).
module tb_data_memory_unit;
  localparam int DEPTH = 256;
  typedef struct {logic [31:0] rd; logic err;} exp_t;
  logic clk = 1'b0;
  logic [1:0] rn, mw, mr, st;
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rdv [2];
  logic [31:0] mem_m [2][DEPTH];
  logic [31:0] rd_m [2];
  int lat [2] = '{2, 1};
  exp_t q0 [$];
  exp_t q1 [$];
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  data_memory_unit_if b0 ();
  data_memory_unit_if b1 ();
  assign b0.MemWriteM = mw[0];
  assign b0.MemtoRegM = mr[0];
  assign b0.ALUResultM = ad[0];
  assign b0.WriteDataM = wd[0];
  assign b1.MemWriteM = mw[1];
  assign b1.MemtoRegM = mr[1];
  assign b1.ALUResultM = ad[1];
  assign b1.WriteDataM = wd[1];
  assign st = {b1.StallM, b0.StallM};
  assign rdv[0] = b0.ReadDataM;
  assign rdv[1] = b1.ReadDataM;
`ifdef DMEM_BOUNDS_CHECK_EN
  logic [1:0] er;
  assign er = {b1.ErrorM, b0.ErrorM};
`endif
  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(2)) u0 (.clk(clk), .rst_n(rn[0]), .bus(b0.slave));
  data_memory_unit #(.DEPTH(DEPTH), .LATENCY(1)) u1 (.clk(clk), .rst_n(rn[1]), .bus(b1.slave));

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s (lat=%0d): got %h expected %h", name, lat[d], act, exp);
  endtask

  // Reference behaviour: word index wraps modulo DEPTH; faults (with the macro) suppress stores and zero loads.
  task automatic apply(input int d, input bit w, input bit r, input logic [31:0] a, input logic [31:0] dat,
                       output logic [31:0] erd, output logic eerr);
    int idx = int'((a >> 2) % DEPTH);
    bit f = 0;
`ifdef DMEM_BOUNDS_CHECK_EN
    f = (a % 4 != 0) || ((a >> 2) >= DEPTH);
`endif
    if (r) rd_m[d] = f ? 32'h0 : mem_m[d][idx];
    if (w && !f) mem_m[d][idx] = dat;
    erd = rd_m[d];
    eerr = f;
  endtask

  task automatic issue(input int d, input bit w, input bit r, input logic [31:0] a, input logic [31:0] dat);
    exp_t e;
    bit s;
    int n = 0;
    mw[d] = w; mr[d] = r; ad[d] = a; wd[d] = dat;
    if (w | r) begin
      apply(d, w, r, a, dat, e.rd, e.err);
      if (d == 0) q0.push_back(e); else q1.push_back(e);
    end
    do begin
      @(negedge clk);
      s = st[d];
      if (!(w | r)) check("nomem_stall", d, {31'b0, s}, 32'h0);
      @(posedge clk);
      #1;
      n++;
    end while (s && n < 20);
    if (s) begin
      total++;
      $display("FAIL stall_bound (lat=%0d): stall still %b after %0d cycles, required 0", lat[d], s, n);
    end
    if (!(w | r)) check("nomem_hold", d, rdv[d], rd_m[d]);
    mw[d] = 0; mr[d] = 0;
  endtask

  task automatic monitor(input int d);
    int c = 0;
    bit p = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rn[d]) begin
        c = 0; p = 0;
      end else begin
        if (st[d]) c++;
        else if (p) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            total++;
            $display("FAIL unexpected_done (lat=%0d): completion with empty scoreboard", lat[d]);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            check("stall_len", d, c, lat[d]);
            check("rdata", d, rdv[d], e.rd);
`ifdef DMEM_BOUNDS_CHECK_EN
            check("error", d, {31'b0, er[d]}, {31'b0, e.err});
`endif
          end
          c = 0;
        end
        p = st[d];
      end
    end
  endtask

  task automatic drive(input int d);
    logic [31:0] a;
    int op;
    check("reset_rd", d, rdv[d], 32'h0);
    check("reset_stall", d, {31'b0, st[d]}, 32'h0);
    for (int i = 0; i < 16; i++) issue(d, 1, 0, i * 4, $urandom);
    issue(d, 1, 0, 32'h10, 32'hDEADBEEF);
    issue(d, 0, 1, 32'h10, 32'h0);
    issue(d, 0, 0, 32'h1234, 32'h0);
    if (d == 0) begin
      mw[0] = 1; ad[0] = 32'h20; wd[0] = 32'h5;
      @(posedge clk);
      #1;
      rn[0] = 0; mw[0] = 0;
      #1;
      check("rst_stall", d, {31'b0, st[0]}, 32'h0);
      check("rst_rd", d, rdv[0], 32'h0);
      rd_m[0] = 0;
      @(negedge clk);
      #1;
      rn[0] = 1;
      @(posedge clk);
      #1;
      issue(d, 0, 1, 32'h20, 32'h0);
    end
    issue(d, 0, 1, 32'h0, 32'h0);
    issue(d, 1, 0, 32'h4, 32'hA5A5A5A5);
    issue(d, 0, 1, 32'h4, 32'h0);
    issue(d, 1, 0, 32'h402, 32'h12345678);
    issue(d, 0, 1, 32'h400, 32'h0);
    issue(d, 0, 1, 32'h0, 32'h0);
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 3);
      a = $urandom;
      a[9:6] = 4'h0;
      if ($urandom_range(0, 3) != 0) begin
        a[31:10] = '0;
        a[1:0] = 2'b00;
      end
      issue(d, op[0], op[1], a, $urandom);
    end
  endtask

  initial begin
    rn = 2'b00; mw = 0; mr = 0;
    for (int d = 0; d < 2; d++) begin
      ad[d] = 0; wd[d] = 0; rd_m[d] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rn = 2'b11;
    fork
      monitor(0);
      monitor(1);
    join_none
    fork
      drive(0);
      drive(1);
    join
    repeat (3) @(posedge clk);
    check("q0_drained", 0, q0.size(), 32'h0);
    check("q1_drained", 1, q1.size(), 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
